// File: rtl/led_ctrl_pkg.sv
// Shared encodings and small helpers for the RGB LED mode controller.
package led_ctrl_pkg;

    localparam logic [2:0] MODE_OFF   = 3'd0;
    localparam logic [2:0] MODE_RED   = 3'd1;
    localparam logic [2:0] MODE_GREEN = 3'd2;
    localparam logic [2:0] MODE_BLUE  = 3'd3;
    localparam logic [2:0] MODE_CYCLE = 3'd4;

    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;

    typedef enum logic [2:0] {
        ST_OFF   = MODE_OFF,
        ST_RED   = MODE_RED,
        ST_GREEN = MODE_GREEN,
        ST_BLUE  = MODE_BLUE,
        ST_CYCLE = MODE_CYCLE
    } mode_e;

    function automatic logic [1:0] next_colour(input logic [1:0] col);
        logic [1:0] nxt;
        case (col)
            COL_R:   nxt = COL_G;
            COL_G:   nxt = COL_B;
            default: nxt = COL_R;
        endcase
        return nxt;
    endfunction

    // Returns {red, green, blue} with only the indexed colour driven by 'on'.
    function automatic logic [2:0] colour_rgb(input logic [1:0] col, input logic on);
        logic [2:0] rgb;
        case (col)
            COL_R:   rgb = {on, 1'b0, 1'b0};
            COL_G:   rgb = {1'b0, on, 1'b0};
            COL_B:   rgb = {1'b0, 1'b0, on};
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Debounces one synchronised button level and emits a one-cycle press event
// in the first cycle the debounced level reads high.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          press_q, press_d;

    // Count how long raw has disagreed with the stable level.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (raw == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = raw;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        press_d = stable_d & ~stable_q;
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/led_mode_controller.sv
// Button-driven RGB LED sequencer: debounced presses step a mode FSM that
// selects solid, blinking or rotating colour output.
module led_mode_controller
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_button0,
    input  logic       push_button1,
    output logic       led_red,
    output logic       led_green,
    output logic       led_blue,
    output logic [2:0] mode
);

    localparam int TW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(BLINK_CYCLES - 1);

    logic press0_s, press1_s;
    logic stable0_s, stable1_s;
    logic unused_stable_s;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
        .clock  (clock),
        .reset  (reset),
        .raw    (push_button0),
        .stable (stable0_s),
        .press  (press0_s)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clock  (clock),
        .reset  (reset),
        .raw    (push_button1),
        .stable (stable1_s),
        .press  (press1_s)
    );

    // The debounced levels themselves are not needed at this level.
    assign unused_stable_s = stable0_s ^ stable1_s;

    mode_e         mode_q, mode_d;
    logic          blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [1:0]    col_q, col_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    led_q, led_d;
    logic          changed_s;
    logic          tick_s;

    // Mode/blink next state, tick generation and LED decode.
    always_comb begin
        mode_d  = mode_q;
        blink_d = blink_q;
        if (press0_s && press1_s) begin
            mode_d  = ST_OFF;
            blink_d = 1'b0;
        end else if (press0_s) begin
            case (mode_q)
                ST_OFF:   mode_d = ST_RED;
                ST_RED:   mode_d = ST_GREEN;
                ST_GREEN: mode_d = ST_BLUE;
                ST_BLUE:  mode_d = ST_CYCLE;
                ST_CYCLE: mode_d = ST_OFF;
                default:  mode_d = ST_RED;
            endcase
        end else if (press1_s) begin
            case (mode_q)
                ST_RED, ST_GREEN, ST_BLUE, ST_CYCLE: blink_d = ~blink_q;
                default:                             blink_d = blink_q;
            endcase
        end else begin
            mode_d  = mode_q;
            blink_d = blink_q;
        end

        // A mode or blink change restarts the tick period and suppresses the tick.
        changed_s = (mode_d != mode_q) || (blink_d != blink_q);
        tick_s    = (tcnt_q == TCNT_LAST) && !changed_s;

        if (changed_s) begin
            tcnt_d  = '0;
            phase_d = 1'b1;
            col_d   = COL_R;
        end else begin
            tcnt_d  = tick_s ? '0 : tcnt_q + TW'(1);
            if (blink_q) begin
                phase_d = tick_s ? ~phase_q : phase_q;
            end else begin
                phase_d = 1'b1;
            end
            if ((mode_q == ST_CYCLE) && tick_s) begin
                col_d = next_colour(col_q);
            end else begin
                col_d = col_q;
            end
        end

        case (mode_q)
            ST_RED:   led_d = colour_rgb(COL_R, phase_q);
            ST_GREEN: led_d = colour_rgb(COL_G, phase_q);
            ST_BLUE:  led_d = colour_rgb(COL_B, phase_q);
            ST_CYCLE: led_d = colour_rgb(col_q, phase_q);
            default:  led_d = 3'b000;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q  <= ST_OFF;
            blink_q <= 1'b0;
            phase_q <= 1'b1;
            col_q   <= COL_R;
            tcnt_q  <= '0;
            led_q   <= 3'b000;
        end else begin
            mode_q  <= mode_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            col_q   <= col_d;
            tcnt_q  <= tcnt_d;
            led_q   <= led_d;
        end
    end

    assign led_red   = led_q[2];
    assign led_green = led_q[1];
    assign led_blue  = led_q[0];
    assign mode      = mode_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// Scoreboard bench for led_mode_controller with short debounce and blink periods.
module tb_led_mode_controller;

    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_G   = 3'b010;
    localparam logic [2:0] L_B   = 3'b001;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pb0   = 1'b1;
    logic       pb1   = 1'b1;
    logic       led_red, led_green, led_blue;
    logic [2:0] mode;

    int cyc       = 0;
    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int         cyc;
        logic [2:0] mode;
        logic       chk_led;
        logic [2:0] led;
        string      name;
    } exp_t;

    exp_t sb[$];

    led_mode_controller #(
        .DEBOUNCE_CYCLES (4),
        .BLINK_CYCLES    (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .push_button0 (pb0),
        .push_button1 (pb1),
        .led_red      (led_red),
        .led_green    (led_green),
        .led_blue     (led_blue),
        .mode         (mode)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic void push_exp(input int c, input logic [2:0] m, input logic cl,
                                     input logic [2:0] l, input string nm);
        exp_t e;
        e.cyc = c; e.mode = m; e.chk_led = cl; e.led = l; e.name = nm;
        sb.push_back(e);
    endfunction

    function automatic logic [2:0] solid_led(input logic [2:0] m);
        case (m)
            3'd1:    return L_R;
            3'd2:    return L_G;
            3'd3:    return L_B;
            3'd4:    return L_R;
            default: return L_OFF;
        endcase
    endfunction

    task automatic test_reset();
        int t0;
        exp_t e;
        @(negedge clock);
        t0 = cyc;
        for (int k = 1; k <= 7; k++) push_exp(t0 + k, 3'd0, 1'b1, L_OFF, "reset_quiet");
        push_exp(t0 + 8, 3'd1, 1'b1, L_OFF, "reset_first_mode");
        push_exp(t0 + 9, 3'd1, 1'b1, L_R, "reset_first_led");
        for (int k = 0; k < 16; k++) begin
            reset = (k < 3);
            pb0   = (k < 8);
            pb1   = (k < 3);
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total_cnt++;
                if (mode !== e.mode || (e.chk_led && {led_red, led_green, led_blue} !== e.led))
                    $display("FAIL %s cyc %0d: mode=%0d led=%b required mode=%0d led=%b",
                             e.name, cyc, mode, {led_red, led_green, led_blue}, e.mode, e.led);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_glitch();
        int t0;
        exp_t e;
        t0 = cyc;
        for (int k = 1; k <= 14; k++) push_exp(t0 + k, 3'd0, 1'b1, L_OFF, "glitch_no_event");
        push_exp(t0 + 15, 3'd1, 1'b1, L_OFF, "press_latency_mode");
        for (int k = 16; k <= 20; k++) push_exp(t0 + k, 3'd1, 1'b1, L_R, "press_latency_led");
        for (int k = 0; k < 24; k++) begin
            reset = (k == 0);
            pb0   = (k >= 3 && k < 6) || (k >= 10 && k < 16);
            pb1   = 1'b0;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total_cnt++;
                if (mode !== e.mode || (e.chk_led && {led_red, led_green, led_blue} !== e.led))
                    $display("FAIL %s cyc %0d: mode=%0d led=%b required mode=%0d led=%b",
                             e.name, cyc, mode, {led_red, led_green, led_blue}, e.mode, e.led);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_mode_cycle();
        int t0;
        int p;
        int ph;
        logic [2:0] lv;
        exp_t e;
        t0 = cyc;
        push_exp(t0 + 1, 3'd0, 1'b1, L_OFF, "cycle_reset");
        for (int i = 0; i < 4; i++) begin
            p = 2 + 8 * i;
            push_exp(t0 + p + 4, 3'(i), 1'b0, L_OFF, "advance_before");
            push_exp(t0 + p + 5, 3'(i + 1), 1'b0, L_OFF, "advance_mode");
            push_exp(t0 + p + 6, 3'(i + 1), 1'b1, solid_led(3'(i + 1)), "advance_led");
        end
        for (int j = 1; j <= 32; j++) begin
            ph = (j - 1) / 8;
            lv = (ph == 1) ? L_G : (ph == 2) ? L_B : L_R;
            push_exp(t0 + 31 + j, 3'd4, 1'b1, lv, "cycle_rotate");
        end
        push_exp(t0 + 70, 3'd4, 1'b0, L_OFF, "wrap_before");
        push_exp(t0 + 71, 3'd0, 1'b0, L_OFF, "wrap_mode");
        push_exp(t0 + 72, 3'd0, 1'b1, L_OFF, "wrap_led");
        for (int k = 0; k < 80; k++) begin
            reset = (k == 0);
            pb0   = (k >= 2 && k < 34 && ((k - 2) % 8) < 4) || (k >= 66 && k < 70);
            pb1   = 1'b0;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total_cnt++;
                if (mode !== e.mode || (e.chk_led && {led_red, led_green, led_blue} !== e.led))
                    $display("FAIL %s cyc %0d: mode=%0d led=%b required mode=%0d led=%b",
                             e.name, cyc, mode, {led_red, led_green, led_blue}, e.mode, e.led);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_blink();
        int t0;
        logic [2:0] lv;
        exp_t e;
        t0 = cyc;
        push_exp(t0 + 12, 3'd1, 1'b0, L_OFF, "blink_setup_red");
        push_exp(t0 + 13, 3'd2, 1'b0, L_OFF, "blink_setup_green");
        for (int k = 14; k <= 74; k++) begin
            lv = ((k >= 30 && k < 38) || (k >= 46 && k < 54)) ? L_OFF : L_G;
            push_exp(t0 + k, 3'd2, 1'b1, lv, "blink_green");
        end
        for (int k = 0; k < 80; k++) begin
            reset = 1'b0;
            pb0   = (k < 16) && ((k % 8) < 4);
            pb1   = (k >= 16 && k < 20) || (k >= 48 && k < 52);
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total_cnt++;
                if (mode !== e.mode || (e.chk_led && {led_red, led_green, led_blue} !== e.led))
                    $display("FAIL %s cyc %0d: mode=%0d led=%b required mode=%0d led=%b",
                             e.name, cyc, mode, {led_red, led_green, led_blue}, e.mode, e.led);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_gesture();
        int t0;
        exp_t e;
        t0 = cyc;
        push_exp(t0 + 4, 3'd2, 1'b0, L_OFF, "gesture_setup_green");
        push_exp(t0 + 5, 3'd3, 1'b0, L_OFF, "gesture_setup_blue");
        for (int k = 6; k <= 21; k++) push_exp(t0 + k, 3'd3, 1'b1, L_B, "gesture_blue_on");
        for (int k = 22; k <= 28; k++) push_exp(t0 + k, 3'd3, 1'b1, L_OFF, "gesture_blue_blink");
        for (int k = 29; k <= 44; k++) push_exp(t0 + k, 3'd0, 1'b1, L_OFF, "gesture_off");
        push_exp(t0 + 45, 3'd1, 1'b1, L_OFF, "gesture_after_mode");
        for (int k = 46; k <= 66; k++) push_exp(t0 + k, 3'd1, 1'b1, L_R, "gesture_blink_cleared");
        for (int k = 0; k < 72; k++) begin
            reset = 1'b0;
            pb0   = (k < 4) || (k >= 24 && k < 28) || (k >= 40 && k < 44);
            pb1   = (k >= 8 && k < 12) || (k >= 24 && k < 28) || (k >= 32 && k < 36);
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total_cnt++;
                if (mode !== e.mode || (e.chk_led && {led_red, led_green, led_blue} !== e.led))
                    $display("FAIL %s cyc %0d: mode=%0d led=%b required mode=%0d led=%b",
                             e.name, cyc, mode, {led_red, led_green, led_blue}, e.mode, e.led);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        exp_t e;
        t0 = cyc;
        push_exp(t0 + 4, 3'd1, 1'b0, L_OFF, "mid_setup");
        push_exp(t0 + 5, 3'd2, 1'b0, L_OFF, "mid_setup");
        push_exp(t0 + 6, 3'd2, 1'b1, L_G, "mid_setup_led");
        push_exp(t0 + 12, 3'd2, 1'b0, L_OFF, "mid_setup");
        push_exp(t0 + 13, 3'd3, 1'b0, L_OFF, "mid_setup");
        push_exp(t0 + 14, 3'd3, 1'b1, L_B, "mid_setup_led");
        push_exp(t0 + 20, 3'd3, 1'b0, L_OFF, "mid_setup");
        push_exp(t0 + 21, 3'd4, 1'b0, L_OFF, "mid_setup");
        push_exp(t0 + 22, 3'd4, 1'b1, L_R, "mid_cycle_start");
        push_exp(t0 + 40, 3'd4, 1'b1, L_B, "mid_cycle_blue");
        push_exp(t0 + 41, 3'd4, 1'b0, L_OFF, "mid_debounce");
        push_exp(t0 + 42, 3'd4, 1'b0, L_OFF, "mid_debounce");
        for (int k = 43; k <= 47; k++) push_exp(t0 + k, 3'd0, 1'b1, L_OFF, "mid_reset_state");
        push_exp(t0 + 48, 3'd1, 1'b1, L_OFF, "mid_full_debounce");
        for (int k = 49; k <= 55; k++) push_exp(t0 + k, 3'd1, 1'b1, L_R, "mid_red");
        for (int k = 0; k < 60; k++) begin
            reset = (k == 42);
            pb0   = (k < 4) || (k >= 8 && k < 12) || (k >= 16 && k < 20) || (k >= 40 && k < 52);
            pb1   = 1'b0;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total_cnt++;
                if (mode !== e.mode || (e.chk_led && {led_red, led_green, led_blue} !== e.led))
                    $display("FAIL %s cyc %0d: mode=%0d led=%b required mode=%0d led=%b",
                             e.name, cyc, mode, {led_red, led_green, led_blue}, e.mode, e.led);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_mode_cycle();
        test_blink();
        test_reset_gesture();
        test_reset_mid();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            total_cnt++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/led_mode_controller.md
Name: led_mode_controller

Overview:
Sequences the board RGB LED from the two push buttons. It debounces both buttons and turns clean presses into one-cycle events. A mode FSM then selects solid, blinking or rotating colour output. It sits between the button synchroniser/inverter wrapper (active-high push_button0/1 in) and the LED driver (active-high led_red/green/blue out), replacing hand-written main logic.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a raw button level must hold before the stable level changes; minimum 2.
BLINK_CYCLES, 25000000, cycles per blink/rotate tick; minimum 2.

Ports:
clock  input  1  system clock
reset  input  1  synchronous reset, active-high
push_button0  input  1  advance-mode button, active-high, already synchronised
push_button1  input  1  blink-toggle button, active-high, already synchronised
led_red  output  1  red LED on, active-high, registered
led_green  output  1  green LED on, active-high, registered
led_blue  output  1  blue LED on, active-high, registered
mode  output  3  current mode encoding, registered

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All state updates on the rising edge of clock.
- Reset values:
  - mode=OFF(0), blink_en=0, phase=1, colour index=R.
  - Both debounce counters=0, stable levels=0.
  - led_* = 0.
  - Reset applied mid-operation discards any partial debounce count and any pending event.
- Debounce, per button:
  - cnt clears whenever raw == stable.
  - While raw != stable, cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 and raw != stable: stable <= raw, cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - press pulse is high for exactly one cycle: the cycle after stable goes 0->1.
  - Release produces no event.
- Mode FSM, modes OFF=0, RED=1, GREEN=2, BLUE=3, CYCLE=4; codes 5-7 unreachable and decode as OFF.
  - press0 alone: OFF->RED->GREEN->BLUE->CYCLE->OFF.
  - press1 alone: blink_en <= ~blink_en. Ignored in OFF, where blink_en is unchanged.
  - press0 and press1 in the same cycle: mode <= OFF, blink_en <= 0. This is the reset gesture.
- Tick generator:
  - tcnt runs 0..BLINK_CYCLES-1 and wraps.
  - tick is high in the cycle tcnt == BLINK_CYCLES-1.
  - On any mode change or blink_en change: tcnt <= 0, phase <= 1, colour index <= R. No tick is issued in that cycle.
- phase toggles on every tick when blink_en = 1. Otherwise phase is held at 1.
- CYCLE mode: colour index rotates R->G->B->R on each tick. Entry to CYCLE always starts at R.
- LED decode, registered (led_* follow mode/phase/index by exactly 1 cycle):
  - OFF: all 0.
  - RED/GREEN/BLUE: the selected colour = phase; others 0.
  - CYCLE: the colour at index = phase; others 0.
- Latency from raw press held to LED change: DEBOUNCE_CYCLES + 2 cycles.
  - stable update (cnt reaches DEBOUNCE_CYCLES-1): DEBOUNCE_CYCLES cycles.
  - press pulse: +1 cycle.
  - mode register updates on the edge ending the press-pulse cycle; led_* follow 1 cycle after that.
- Counter widths: $clog2(param) bits. No overflow is possible because counters clear at their terminal count.

Decomposition:
- Shared package led_ctrl_pkg:
  - Mode localparams MODE_OFF..MODE_CYCLE (3-bit).
  - Colour index localparams COL_R/G/B (2-bit).
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clock, reset, raw, stable, press), instantiated twice.
- Tick generator, FSM and LED decode stay in led_mode_controller.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8):
1. Reset held 3 cycles with buttons high -> led_*=0, mode=0 throughout and on the first cycle after release. Buttons then still need 4 cycles before any event.
2. push_button0 high for 3 cycles then low -> no press, mode stays 0. Held 4+ cycles -> press once, mode=1, led_red=1 exactly 6 cycles after first high.
3. Five clean press0 events -> mode 1,2,3,4,0. In mode 4 with no further presses, led colour rotates R,G,B,R every 8 cycles, starting R.
4. In mode 2 (GREEN), press1 -> blink_en=1; led_green toggles every 8 cycles starting at 1. A second press1 -> led_green steady 1.
5. push_button0 and push_button1 asserted on the same cycle for 4 cycles in mode 3 with blink on -> mode=0, blink_en=0, all LEDs 0.
6. Reset asserted mid-debounce (cnt=2) and mid-CYCLE -> all state back to reset values. Button held afterwards needs a full 4 cycles again to register.
